// File: rtl/maze_player_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : maze_player_ctrl
//  Description : Tile-based maze player controller. A free-running divider
//                produces a game tick. On each tick a one-hot direction
//                request fetches the wall bits of the current tile and of
//                the neighbour tile over a req/ack port. The controller then
//                either moves the sprite STEP pixels or blocks the move at a
//                wall or at the maze edge. Position is kept as a tile
//                row/column plus an in-tile offset and is updated without
//                any divide or modulo.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                btn_home          - return to the spawn position
//                btn_dir[3:0]      - direction request {down,right,left,up}
//                level_load        - new-level pulse, also respawns
//                goal_row/goal_col - goal tile
//                wall_req/row/col  - wall lookup request and tile address
//                wall_ack/data     - lookup response {top,bottom,left,right}
//                pos_x/pos_y       - sprite pixel position
//                cur_row/cur_col   - tile holding the sprite
//                busy              - high while a move is being evaluated
//                level_done        - one-cycle pulse on goal-tile entry
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_player_ctrl #(
    parameter int TILE_W      = 80,
    parameter int TILE_H      = 60,
    parameter int NUM_ROWS    = 8,
    parameter int NUM_COLS    = 8,
    parameter int WALL_MARGIN = 4,
    parameter int SPRITE      = 10,
    parameter int STEP        = 2,
    parameter int TICK_DIV    = 200000,
    parameter int START_X     = 394,
    parameter int START_Y     = 41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_home,
    input  logic [3:0]  btn_dir,
    input  logic        level_load,
    input  logic [4:0]  goal_row,
    input  logic [4:0]  goal_col,
    output logic        wall_req,
    output logic [4:0]  wall_row,
    output logic [4:0]  wall_col,
    input  logic        wall_ack,
    input  logic [3:0]  wall_data,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic [4:0]  cur_row,
    output logic [4:0]  cur_col,
    output logic        busy,
    output logic        level_done
);

    localparam int              c_tick_w    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    // Spawn tile and offset are elaboration-time constants.
    localparam logic [4:0]  c_start_row  = 5'(START_Y / TILE_H);
    localparam logic [4:0]  c_start_col  = 5'(START_X / TILE_W);
    localparam logic [9:0]  c_start_yoff = 10'(START_Y % TILE_H);
    localparam logic [9:0]  c_start_xoff = 10'(START_X % TILE_W);
    localparam logic [9:0]  c_step10     = 10'(STEP);
    localparam logic [9:0]  c_margin10   = 10'(WALL_MARGIN);
    localparam logic [10:0] c_step11     = 11'(STEP);
    localparam logic [10:0] c_sprite11   = 11'(SPRITE);
    localparam logic [10:0] c_bot_lim11  = 11'(TILE_H - WALL_MARGIN);
    localparam logic [10:0] c_rgt_lim11  = 11'(TILE_W - WALL_MARGIN);
    localparam logic [11:0] c_step12     = 12'(STEP);
    localparam logic [11:0] c_max_y12    = 12'(NUM_ROWS * TILE_H - SPRITE);
    localparam logic [11:0] c_max_x12    = 12'(NUM_COLS * TILE_W - SPRITE);
    localparam logic [4:0]  c_last_row   = 5'(NUM_ROWS - 1);
    localparam logic [4:0]  c_last_col   = 5'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_CUR = 2'd1,
        ST_RD_ADJ = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [c_tick_w-1:0]   tick_cnt_q, tick_cnt_d;
    logic [4:0]            row_q, row_d, col_q, col_d;
    logic [9:0]            x_off_q, x_off_d, y_off_q, y_off_d;
    logic [3:0]            dir_q, dir_d, cur_w_q, cur_w_d, adj_w_q, adj_w_d;
    logic                  wall_req_q, wall_req_d;
    logic [4:0]            wall_row_q, wall_row_d, wall_col_q, wall_col_d;
    logic                  busy_q, busy_d, level_done_q, level_done_d;
    logic                  at_goal_q, at_goal_d;

    logic                  w_tick, w_dir_onehot, w_blocked, w_at_goal;
    logic [4:0]            w_adj_row, w_adj_col;
    logic [9:0]            w_x_sum, w_y_sum;

    assign pos_x      = 11'(col_q) * 11'(TILE_W) + 11'(x_off_q);
    assign pos_y      = 11'(row_q) * 11'(TILE_H) + 11'(y_off_q);
    assign cur_row    = row_q;
    assign cur_col    = col_q;
    assign wall_req   = wall_req_q;
    assign wall_row   = wall_row_q;
    assign wall_col   = wall_col_q;
    assign busy       = busy_q;
    assign level_done = level_done_q;

    assign w_tick       = (tick_cnt_q == c_tick_last);
    assign w_dir_onehot = (btn_dir != 4'd0) && ((btn_dir & (btn_dir - 4'd1)) == 4'd0);
    assign w_at_goal    = (row_q == goal_row) && (col_q == goal_col);
    assign w_x_sum      = x_off_q + c_step10;
    assign w_y_sum      = y_off_q + c_step10;

    // Neighbour tile in the latched direction; the maze edge clamps to self.
    always_comb begin
        w_adj_row = row_q;
        w_adj_col = col_q;
        if (dir_q[0])      w_adj_row = (row_q == 5'd0)       ? row_q : row_q - 5'd1;
        else if (dir_q[1]) w_adj_col = (col_q == 5'd0)       ? col_q : col_q - 5'd1;
        else if (dir_q[2]) w_adj_col = (col_q == c_last_col) ? col_q : col_q + 5'd1;
        else if (dir_q[3]) w_adj_row = (row_q == c_last_row) ? row_q : row_q + 5'd1;
    end

    // A wall only matters once the sprite is within the margin of that edge;
    // the maze boundary blocks regardless of wall bits.
    always_comb begin
        w_blocked = 1'b0;
        if (dir_q[0])
            w_blocked = ((y_off_q <= c_margin10) && (cur_w_q[3] || adj_w_q[2]))
                        || (pos_y < c_step11);
        else if (dir_q[1])
            w_blocked = ((x_off_q <= c_margin10) && (cur_w_q[1] || adj_w_q[0]))
                        || (pos_x < c_step11);
        else if (dir_q[2])
            w_blocked = ((11'(x_off_q) + c_sprite11 >= c_rgt_lim11) && (cur_w_q[0] || adj_w_q[1]))
                        || ({1'b0, pos_x} + c_step12 > c_max_x12);
        else if (dir_q[3])
            w_blocked = ((11'(y_off_q) + c_sprite11 >= c_bot_lim11) && (cur_w_q[2] || adj_w_q[3]))
                        || ({1'b0, pos_y} + c_step12 > c_max_y12);
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = w_tick ? '0 : tick_cnt_q + c_tick_one;
        row_d        = row_q;
        col_d        = col_q;
        x_off_d      = x_off_q;
        y_off_d      = y_off_q;
        dir_d        = dir_q;
        cur_w_d      = cur_w_q;
        adj_w_d      = adj_w_q;
        wall_req_d   = wall_req_q;
        wall_row_d   = wall_row_q;
        wall_col_d   = wall_col_q;
        level_done_d = w_at_goal && !at_goal_q;
        at_goal_d    = w_at_goal;

        case (state_q)
            ST_IDLE: begin
                // Ticks arriving in other states are simply not looked at.
                if (w_tick && w_dir_onehot) begin
                    dir_d      = btn_dir;
                    wall_req_d = 1'b1;
                    wall_row_d = row_q;
                    wall_col_d = col_q;
                    state_d    = ST_RD_CUR;
                end
            end
            ST_RD_CUR: begin
                if (wall_req_q && wall_ack) begin
                    cur_w_d    = wall_data;
                    wall_req_d = 1'b0;
                    state_d    = ST_RD_ADJ;
                end
            end
            ST_RD_ADJ: begin
                // First cycle here has req low (dropped after the previous
                // ack); raise it with the neighbour address, then wait.
                if (!wall_req_q) begin
                    wall_req_d = 1'b1;
                    wall_row_d = w_adj_row;
                    wall_col_d = w_adj_col;
                end else if (wall_ack) begin
                    adj_w_d    = wall_data;
                    wall_req_d = 1'b0;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_blocked) begin
                    if (dir_q[0]) begin
                        if (y_off_q < c_step10) begin
                            row_d   = row_q - 5'd1;
                            y_off_d = y_off_q + 10'(TILE_H - STEP);
                        end else begin
                            y_off_d = y_off_q - c_step10;
                        end
                    end else if (dir_q[1]) begin
                        if (x_off_q < c_step10) begin
                            col_d   = col_q - 5'd1;
                            x_off_d = x_off_q + 10'(TILE_W - STEP);
                        end else begin
                            x_off_d = x_off_q - c_step10;
                        end
                    end else if (dir_q[2]) begin
                        if (w_x_sum >= 10'(TILE_W)) begin
                            col_d   = col_q + 5'd1;
                            x_off_d = w_x_sum - 10'(TILE_W);
                        end else begin
                            x_off_d = w_x_sum;
                        end
                    end else if (dir_q[3]) begin
                        if (w_y_sum >= 10'(TILE_H)) begin
                            row_d   = row_q + 5'd1;
                            y_off_d = w_y_sum - 10'(TILE_H);
                        end else begin
                            y_off_d = w_y_sum;
                        end
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Respawn overrides any in-flight move; a pending ack is discarded
        // because IDLE never looks at wall_ack.
        if (btn_home || level_load) begin
            row_d        = c_start_row;
            col_d        = c_start_col;
            x_off_d      = c_start_xoff;
            y_off_d      = c_start_yoff;
            wall_req_d   = 1'b0;
            state_d      = ST_IDLE;
            level_done_d = 1'b0;
            // A new level re-arms the goal detector; a plain respawn keeps it.
            at_goal_d    = level_load ? 1'b0 : at_goal_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            row_q        <= c_start_row;
            col_q        <= c_start_col;
            x_off_q      <= c_start_xoff;
            y_off_q      <= c_start_yoff;
            dir_q        <= 4'd0;
            cur_w_q      <= 4'd0;
            adj_w_q      <= 4'd0;
            wall_req_q   <= 1'b0;
            wall_row_q   <= 5'd0;
            wall_col_q   <= 5'd0;
            busy_q       <= 1'b0;
            level_done_q <= 1'b0;
            at_goal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            x_off_q      <= x_off_d;
            y_off_q      <= y_off_d;
            dir_q        <= dir_d;
            cur_w_q      <= cur_w_d;
            adj_w_q      <= adj_w_d;
            wall_req_q   <= wall_req_d;
            wall_row_q   <= wall_row_d;
            wall_col_q   <= wall_col_d;
            busy_q       <= busy_d;
            level_done_q <= level_done_d;
            at_goal_q    <= at_goal_d;
        end
    end

endmodule
`default_nettype wire
